// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader and the PC.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  // Byte stride between consecutive instruction words; the PC+4 adder uses it too.
  localparam int WORD_STRIDE    = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs bytes little-endian into one instruction word: byte k lands in
// bits [8k+7:8k]. Clear wins over load so that unfilled lanes read back as zero.
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [7:0]        data,
  input  logic              is_last,
  output logic [DATA_W-1:0] word,
  output logic              full,
  output logic              last
);

  logic [1:0] lane;

  // The next load fills the top lane and completes the word.
  assign full = (lane == 2'(BYTES_PER_WORD - 1));

  // Lane counter, word register and captured in_last flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane <= '0;
      word <= '0;
      last <= 1'b0;
    end else if (clear) begin
      lane <= '0;
      word <= '0;
      last <= 1'b0;
    end else if (load) begin
      word[{lane, 3'b000} +: 8] <= data;
      lane                      <= lane + 2'd1;
      last                      <= is_last;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Writer side of instruction fetch: packs a host byte stream into 32-bit
// words, writes them at stride-4 addresses and pulses start when done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              start,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W-2:0] word_count
);

  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(WORD_STRIDE);
  localparam logic [ADDR_W-1:0] LAST_SLOT = ~ADDR_W'(WORD_STRIDE - 1);

  loader_state_t     state, nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-2:0] wcount;
  logic              err_q;
  logic              armed;
  logic              accept;
  logic              pk_clear;
  logic              pk_full;
  logic              pk_last;
  logic [DATA_W-1:0] pk_word;
  logic              session_go;

  assign in_ready   = (state == COLLECT);
  assign accept     = in_valid & in_ready;
  assign session_go = (state == IDLE) & load_en & armed;

  // Buffer is empty outside a live word: idle, after each write, or on abort.
  assign pk_clear = (state == IDLE) | (state == WRITE) | ((state == COLLECT) & ~load_en);

  byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk     (clk),
    .rst     (rst),
    .load    (accept & load_en),
    .clear   (pk_clear),
    .data    (in_data),
    .is_last (in_last),
    .word    (pk_word),
    .full    (pk_full),
    .last    (pk_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // Next-state logic; dropping load_en always wins over completion or overflow.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (session_go) nxt = COLLECT;
      COLLECT: begin
        if (!load_en)                             nxt = IDLE;
        else if (accept && (pk_full || in_last))  nxt = WRITE;
      end
      WRITE: begin
        if (!load_en)               nxt = IDLE;
        else if (pk_last)           nxt = DONE;
        else if (ptr == LAST_SLOT)  nxt = ERR;
        else                        nxt = COLLECT;
      end
      DONE:    nxt = IDLE;
      ERR:     if (!load_en) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Address pointer and word counter: reset per session, advance on each write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr    <= '0;
      wcount <= '0;
    end else if (session_go) begin
      ptr    <= '0;
      wcount <= '0;
    end else if (state == WRITE) begin
      ptr    <= ptr + STRIDE;
      wcount <= wcount + 1'b1;
    end
  end

  // Sticky overflow flag, cleared only when a new session begins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              err_q <= 1'b0;
    else if (session_go)   err_q <= 1'b0;
    else if (nxt == ERR)   err_q <= 1'b1;
  end

  // Rising-edge arm: a completed session needs load_en low in IDLE before the next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            armed <= 1'b1;
    else if (state == DONE)              armed <= 1'b0;
    else if (state == IDLE && !load_en)  armed <= 1'b1;
  end

  assign mem_we     = (state == WRITE);
  assign mem_addr   = ptr;
  assign mem_wdata  = pk_word;
  assign start      = (state == DONE);
  assign busy       = (state == COLLECT) | (state == WRITE);
  assign error      = err_q;
  assign word_count = wcount;

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader: a byte-stream model predicts
// the word writes, start pulses and flags for an 8-bit and a 4-bit address DUT.
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, in_last, sel;
  logic       load_en8, load_en4;
  logic       v8, v4, ready;

  logic        rdy8, we8, st8, busy8, err8;
  logic [7:0]  addr8;
  logic [31:0] wd8;
  logic [6:0]  wc8;
  logic        rdy4, we4, st4, busy4, err4;
  logic [3:0]  addr4;
  logic [31:0] wd4;
  logic [2:0]  wc4;

  assign v8    = in_valid & ~sel;
  assign v4    = in_valid & sel;
  assign ready = sel ? rdy4 : rdy8;

  imem_loader #(.ADDR_W(8), .DATA_W(32)) dut8 (
    .clk(clk), .rst(rst), .load_en(load_en8), .in_data(in_data), .in_valid(v8),
    .in_last(in_last), .in_ready(rdy8), .mem_we(we8), .mem_addr(addr8),
    .mem_wdata(wd8), .start(st8), .busy(busy8), .error(err8), .word_count(wc8));

  imem_loader #(.ADDR_W(4), .DATA_W(32)) dut4 (
    .clk(clk), .rst(rst), .load_en(load_en4), .in_data(in_data), .in_valid(v4),
    .in_last(in_last), .in_ready(rdy4), .mem_we(we4), .mem_addr(addr4),
    .mem_wdata(wd4), .start(st4), .busy(busy4), .error(err4), .word_count(wc4));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int starts8 = 0, starts4 = 0;
  int last_we_cyc8 = 0, start_cyc8 = 0;
  logic [39:0] wq8[$];
  logic [39:0] wq4[$];
  logic [39:0] expq[$];
  logic [7:0]  bq[$];

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Capture every write and start pulse; in_ready must be low whenever writing.
  always @(negedge clk) begin
    if (we8) begin
      wq8.push_back({addr8, wd8});
      last_we_cyc8 = cyc;
      check("ready_low_in_write8", {39'd0, rdy8}, 40'd0);
    end
    if (st8) begin
      starts8++;
      start_cyc8 = cyc;
    end
    if (we4) begin
      wq4.push_back({4'h0, addr4, wd4});
      check("ready_low_in_write4", {39'd0, rdy4}, 40'd0);
    end
    if (st4) starts4++;
  end

  // Reference: bytes packed four per word little-endian, zero padded, stride 4.
  task automatic build_model(input int aw);
    int nw;
    logic [31:0] w;
    logic [7:0]  a;
    expq.delete();
    nw = (bq.size() + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++)
        if (4 * i + b < bq.size()) w = w | (32'(bq[4 * i + b]) << (8 * b));
      a = 8'((4 * i) % (1 << aw));
      expq.push_back({a, w});
    end
  endtask

  task automatic cmp_writes(input string tag, input bit use4);
    int n;
    n = use4 ? wq4.size() : wq8.size();
    check({tag, "_count"}, 40'(n), 40'(expq.size()));
    for (int i = 0; i < n && i < expq.size(); i++)
      check($sformatf("%s_w%0d", tag, i), use4 ? wq4[i] : wq8[i], expq[i]);
  endtask

  // Drive the queued bytes with random idle gaps; hold each byte until accepted.
  task automatic send_stream(input bit last_on_end, input int maxgap);
    bit ok;
    for (int i = 0; i < bq.size(); i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
      in_data  = bq[i];
      in_last  = last_on_end && (i == bq.size() - 1);
      in_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
        @(negedge clk);
        if (ready) ok = 1'b1;
        @(posedge clk); #1;
      end
      if (!ok) begin
        check("handshake_timeout", {39'd0, ok}, 40'd1);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic new_session8();
    load_en8 = 1'b0;
    idle(2);
    wq8.delete();
    starts8  = 0;
    load_en8 = 1'b1;
  endtask

  task automatic full_session8(input string tag, input int maxgap);
    new_session8();
    send_stream(1'b1, maxgap);
    idle(5);
    build_model(8);
    cmp_writes(tag, 1'b0);
    check({tag, "_starts"}, 40'(starts8), 40'd1);
    check({tag, "_wcount"}, {33'd0, wc8}, 40'(expq.size()));
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; load_en8 = 1'b0; load_en4 = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    #12;
    check("rst_outputs8", {rdy8, we8, st8, busy8, err8, wc8, addr8, wd8[20:0]}, 40'd0);
    check("rst_wdata8", {8'd0, wd8}, 40'd0);
    check("rst_outputs4", {rdy4, we4, st4, busy4, err4, wc4, addr4, wd4[26:0]}, 40'd0);
    @(posedge clk); #1; rst = 1'b1;
    idle(1);

    // Two full words, last on the eighth byte.
    bq.delete();
    for (int i = 1; i <= 8; i++) bq.push_back(8'(i));
    full_session8("seq8", 0);
    check("start_after_write", 40'(start_cyc8 - last_we_cyc8), 40'd1);
    // load_en still high after DONE: no new session until it drops.
    check("no_rearm_busy", {39'd0, busy8}, 40'd0);

    // Partial second word, upper lanes zero.
    bq.delete();
    for (int i = 0; i < 6; i++) bq.push_back(8'hAA + 8'(i));
    full_session8("part6", 2);

    // Random lengths and contents with random gaps.
    for (int r = 0; r < 4; r++) begin
      bq.delete();
      repeat ($urandom_range(1, 40)) bq.push_back(8'($urandom));
      full_session8($sformatf("rand%0d", r), 3);
    end

    // Abort after two bytes of a word: nothing written, no start.
    new_session8();
    bq.delete(); bq.push_back(8'h11); bq.push_back(8'h22);
    send_stream(1'b0, 0);
    load_en8 = 1'b0;
    idle(4);
    check("abort_writes", 40'(wq8.size()), 40'd0);
    check("abort_starts", 40'(starts8), 40'd0);
    check("abort_busy", {39'd0, busy8}, 40'd0);
    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back(8'h40 + 8'(i));
    full_session8("after_abort", 1);

    // Asynchronous reset mid-COLLECT.
    new_session8();
    bq.delete(); bq.push_back(8'h5A); bq.push_back(8'hA5);
    send_stream(1'b0, 0);
    #1 rst = 1'b0;
    #1;
    check("async_rst8", {rdy8, we8, st8, busy8, err8, wc8, addr8, wd8[20:0]}, 40'd0);
    check("async_rst_wdata8", {8'd0, wd8}, 40'd0);
    #1 rst = 1'b1;
    wq8.delete(); starts8 = 0;
    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back(8'(8'hC0 + 8'(i)));
    send_stream(1'b1, 1);
    idle(5);
    build_model(8);
    cmp_writes("post_rst", 1'b0);
    check("post_rst_starts", 40'(starts8), 40'd1);

    // Address overflow on the 4-bit DUT.
    load_en8 = 1'b0;
    sel = 1'b1;
    wq4.delete(); starts4 = 0;
    load_en4 = 1'b1;
    bq.delete();
    repeat (16) bq.push_back(8'($urandom));
    send_stream(1'b0, 1);
    idle(3);
    build_model(4);
    cmp_writes("ovf", 1'b1);
    check("ovf_error", {39'd0, err4}, 40'd1);
    check("ovf_ready", {39'd0, rdy4}, 40'd0);
    check("ovf_starts", 40'(starts4), 40'd0);
    check("ovf_wcount", {37'd0, wc4}, 40'd4);
    in_data = 8'h77; in_valid = 1'b1;
    idle(3);
    in_valid = 1'b0;
    check("ovf_ignored_bytes", 40'(wq4.size()), 40'd4);
    load_en4 = 1'b0;
    idle(2);
    check("err_sticky_idle", {39'd0, err4}, 40'd1);
    check("err_idle_busy", {39'd0, busy4}, 40'd0);
    load_en4 = 1'b1;
    idle(2);
    check("err_cleared", {39'd0, err4}, 40'd0);
    check("new_session_busy", {39'd0, busy4}, 40'd1);
    check("new_session_wcount", {37'd0, wc4}, 40'd0);
    load_en4 = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
